// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: control-word field bits,
// the six control-word constants, the 4-bit state encoding and the
// instruction class/subop codes.
package cpu_pkg;

    localparam int CW_BITS = 16;

    // Control-word fields touched by the memory words
    localparam int CWB_EAB_ABUS = 12;  // eab <- abus
    localparam int CWB_PC_ABUS  = 11;  // pc  <- abus
    localparam int CWB_DI_EDB   = 10;  // di  <- edb

    localparam logic [CW_BITS-1:0] CW_NOP   = 16'h0000;
    localparam logic [CW_BITS-1:0] CW_FETCH = 16'h5801;
    localparam logic [CW_BITS-1:0] CW_ALU   = 16'hC1A0;
    localparam logic [CW_BITS-1:0] CW_WB    = 16'h01A0;
    localparam logic [CW_BITS-1:0] CW_MRD   = 16'h1600;
    localparam logic [CW_BITS-1:0] CW_JMP   = 16'h0C00;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_ALU    = 4'd3,
        ST_WB     = 4'd4,
        ST_MRD    = 4'd5,
        ST_JMPS   = 4'd6,
        ST_RETIRE = 4'd7,
        ST_HALT   = 4'd8,
        ST_FAULT  = 4'd9
    } state_t;

    // ire[7:6] class; class 11 is the system class, further split by subop
    localparam logic [1:0] CLS_SYS  = 2'b11;
    localparam logic [1:0] SUB_NOP  = 2'b00;
    localparam logic [1:0] SUB_LOAD = 2'b01;
    localparam logic [1:0] SUB_JMP  = 2'b10;
    localparam logic [1:0] SUB_HALT = 2'b11;

    // States that drive a memory request and wait for mem_ack
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MRD) || (s == ST_JMPS);
    endfunction

endpackage

// File: rtl/ctrl_sequencer_mem_wait_timer.sv
// Memory wait timer: counts cycles spent in a request state without mem_ack.
// Ports:
//   clk1, reset : clock, async active-high reset
//   clr         : clear the count (outside request states, or on ack)
//   en          : count this cycle (in request state, no ack)
//   timeout     : this un-acked cycle is the MEM_TMO-th one
module mem_wait_timer #(
    parameter int MEM_TMO = 15
) (
    input  logic clk1,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam logic [7:0] TMO_LAST = 8'(MEM_TMO - 1);

    logic [7:0] wait_cnt;

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset)
            wait_cnt <= 8'd0;
        else if (clr)
            wait_cnt <= 8'd0;
        else if (en)
            wait_cnt <= wait_cnt + 8'd1;
    end

    // Fires on the cycle whose increment would make wait_cnt reach MEM_TMO,
    // so the FSM leaves after exactly MEM_TMO un-acked cycles. en already
    // excludes mem_ack, which is how an ack on that same cycle wins.
    assign timeout = en && (wait_cnt == TMO_LAST);

endmodule

// File: rtl/ctrl_sequencer.sv
// Microsequencer feeding the datapath execution unit. Decodes ire and issues
// one registered control word per clk1 cycle, running fetch/decode/execute/
// writeback plus the memory req/ack handshake (NOP words while waiting).
// Ports:
//   clk1, reset : clock, async active-high reset
//   run         : start next instruction at a boundary (IDLE/RETIRE)
//   ire         : instruction byte, sampled in DECODE only
//   mem_ack     : memory done with current request
//   cword       : registered control word (value for the state being entered)
//   mem_req     : memory request, held until ack
//   halted      : in HALT
//   fault       : sticky memory timeout
//   state_dbg   : current state encoding
//   instr_cnt   : retired-instruction count, wrapping
module ctrl_sequencer
    import cpu_pkg::*;
#(
    parameter int CW_W    = 16,
    parameter int MEM_TMO = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             run,
    input  logic [7:0]       ire,
    input  logic             mem_ack,
    output logic [CW_W-1:0]  cword,
    output logic             mem_req,
    output logic             halted,
    output logic             fault,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t          state, state_nxt;
    logic [CW_W-1:0] cw_nxt;
    logic            in_req, tmo;

    // Register fields are consumed by the datapath, not the sequencer
    logic unused_ire;
    assign unused_ire = ^{ire[5:4], ire[1:0]};

    assign in_req = is_mem_state(state);

    mem_wait_timer #(.MEM_TMO(MEM_TMO)) u_timer (
        .clk1    (clk1),
        .reset   (reset),
        .clr     (!in_req || mem_ack),
        .en      (in_req && !mem_ack),
        .timeout (tmo)
    );

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cw_nxt    = CW_NOP;
        case (state)
            ST_IDLE:   if (run) state_nxt = ST_FETCH;
            ST_FETCH:  if (mem_ack) state_nxt = ST_DECODE;
                       else if (tmo) state_nxt = ST_FAULT;
            ST_DECODE: begin
                if (ire[7:6] != CLS_SYS)
                    state_nxt = ST_ALU;
                else begin
                    case (ire[3:2])
                        SUB_NOP:  state_nxt = ST_RETIRE;
                        SUB_LOAD: state_nxt = ST_MRD;
                        SUB_JMP:  state_nxt = ST_JMPS;
                        default:  state_nxt = ST_HALT;
                    endcase
                end
            end
            ST_ALU:    state_nxt = ST_WB;
            ST_WB:     state_nxt = ST_RETIRE;
            ST_MRD:    if (mem_ack) state_nxt = ST_WB;
                       else if (tmo) state_nxt = ST_FAULT;
            ST_JMPS:   if (mem_ack) state_nxt = ST_RETIRE;
                       else if (tmo) state_nxt = ST_FAULT;
            ST_RETIRE: state_nxt = run ? ST_FETCH : ST_IDLE;
            ST_HALT:   state_nxt = ST_HALT;
            ST_FAULT:  state_nxt = ST_FAULT;
            default:   state_nxt = ST_IDLE;
        endcase

        // Outputs are registered, so select them from the state being entered
        case (state_nxt)
            ST_FETCH: cw_nxt = CW_FETCH;
            ST_ALU:   cw_nxt = CW_ALU;
            ST_WB:    cw_nxt = CW_WB;
            ST_MRD:   cw_nxt = CW_MRD;
            ST_JMPS:  cw_nxt = CW_JMP;
            default:  cw_nxt = CW_NOP;
        endcase
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            cword     <= '0;
            mem_req   <= 1'b0;
            halted    <= 1'b0;
            fault     <= 1'b0;
            instr_cnt <= '0;
        end else begin
            cword   <= cw_nxt;
            mem_req <= is_mem_state(state_nxt);
            halted  <= (state_nxt == ST_HALT);
            // FAULT only exits via reset, so this stays set once taken
            fault   <= (state_nxt == ST_FAULT);
            // RETIRE always lasts one cycle: count once on entry
            if (state_nxt == ST_RETIRE)
                instr_cnt <= instr_cnt + 1'b1;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_ctrl_sequencer.sv
module tb_ctrl_sequencer;

    logic        clk1 = 1'b0;
    logic        reset, run, mem_ack;
    logic [7:0]  ire;
    logic [15:0] cword;
    logic        mem_req, halted, fault;
    logic [3:0]  state_dbg;
    logic [3:0]  instr_cnt;

    int tests = 0;
    int fails = 0;

    ctrl_sequencer #(.CW_W(16), .MEM_TMO(15), .CNT_W(4)) dut (
        .clk1      (clk1),
        .reset     (reset),
        .run       (run),
        .ire       (ire),
        .mem_ack   (mem_ack),
        .cword     (cword),
        .mem_req   (mem_req),
        .halted    (halted),
        .fault     (fault),
        .state_dbg (state_dbg),
        .instr_cnt (instr_cnt)
    );

    always #5 clk1 = ~clk1;

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // state / cword / mem_req in one call
    task automatic co(input string tag, input logic [3:0] st, input logic [15:0] cw, input logic rq);
        chk({tag, "_state"}, 32'(state_dbg), 32'(st));
        chk({tag, "_cword"}, 32'(cword), 32'(cw));
        chk({tag, "_req"}, 32'(mem_req), 32'(rq));
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; ire = 8'h00; mem_ack = 1'b0;
        #2;
        co("rst", 4'd0, 16'h0000, 1'b0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_cnt", 32'(instr_cnt), 32'd0);
        step; step;
        reset = 1'b0;

        // 1: ADD, acked immediately
        run = 1'b1; ire = 8'h16; mem_ack = 1'b1;
        step; co("t1_fetch", 4'd1, 16'h5801, 1'b1);
        step; co("t1_decode", 4'd2, 16'h0000, 1'b0);
        step; co("t1_alu", 4'd3, 16'hC1A0, 1'b0);
        step; co("t1_wb", 4'd4, 16'h01A0, 1'b0);
        step; co("t1_retire", 4'd7, 16'h0000, 1'b0);
        chk("t1_cnt", 32'(instr_cnt), 32'd1);
        run = 1'b0;
        step; co("t1_idle", 4'd0, 16'h0000, 1'b0);

        // 2: LOAD with ack delayed 3 cycles in MRD
        run = 1'b1; ire = 8'hC4; mem_ack = 1'b1;
        step; co("t2_fetch", 4'd1, 16'h5801, 1'b1);
        step; co("t2_decode", 4'd2, 16'h0000, 1'b0);
        mem_ack = 1'b0;
        step; co("t2_mrd0", 4'd5, 16'h1600, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step; co("t2_mrd_hold", 4'd5, 16'h1600, 1'b1);
        end
        mem_ack = 1'b1;
        step; co("t2_wb", 4'd4, 16'h01A0, 1'b0);
        chk("t2_fault", 32'(fault), 32'd0);
        step; co("t2_retire", 4'd7, 16'h0000, 1'b0);
        chk("t2_cnt", 32'(instr_cnt), 32'd2);
        run = 1'b0;
        step; co("t2_idle", 4'd0, 16'h0000, 1'b0);

        // 3a: ack on the 15th wait cycle of FETCH wins over timeout
        run = 1'b1; ire = 8'h16; mem_ack = 1'b0;
        step; co("t3a_fetch", 4'd1, 16'h5801, 1'b1);
        for (int i = 0; i < 14; i++) begin
            step; co("t3a_wait", 4'd1, 16'h5801, 1'b1);
        end
        mem_ack = 1'b1;
        step; co("t3a_decode", 4'd2, 16'h0000, 1'b0);
        chk("t3a_fault", 32'(fault), 32'd0);
        step; step;
        step; chk("t3a_cnt", 32'(instr_cnt), 32'd3);
        run = 1'b0;
        step; co("t3a_idle", 4'd0, 16'h0000, 1'b0);

        // 3b: never acked -> FAULT after 15 wait cycles, sticky
        run = 1'b1; mem_ack = 1'b0;
        step; co("t3b_fetch", 4'd1, 16'h5801, 1'b1);
        for (int i = 0; i < 14; i++) begin
            step; co("t3b_wait", 4'd1, 16'h5801, 1'b1);
        end
        step; co("t3b_fault", 4'd9, 16'h0000, 1'b0);
        chk("t3b_fault_flag", 32'(fault), 32'd1);
        mem_ack = 1'b1;
        step; step; co("t3b_sticky", 4'd9, 16'h0000, 1'b0);
        chk("t3b_sticky_flag", 32'(fault), 32'd1);
        reset = 1'b1; #1;
        chk("t3b_rst_fault", 32'(fault), 32'd0);
        chk("t3b_rst_cnt", 32'(instr_cnt), 32'd0);
        step; reset = 1'b0;

        // 4: HALT holds through run toggling
        run = 1'b1; ire = 8'hCC; mem_ack = 1'b1;
        step; step;
        step; co("t4_halt", 4'd8, 16'h0000, 1'b0);
        chk("t4_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            run = i[0];
            step;
            chk("t4_hold_state", 32'(state_dbg), 32'd8);
            chk("t4_hold_halted", 32'(halted), 32'd1);
            chk("t4_hold_cnt", 32'(instr_cnt), 32'd0);
        end
        reset = 1'b1; #1;
        chk("t4_rst_halted", 32'(halted), 32'd0);
        step; reset = 1'b0;

        // 5: drop run during ALU -> instruction completes, then IDLE
        run = 1'b1; ire = 8'h16; mem_ack = 1'b1;
        step; step;
        step; co("t5_alu", 4'd3, 16'hC1A0, 1'b0);
        run = 1'b0;
        step; co("t5_wb", 4'd4, 16'h01A0, 1'b0);
        step; co("t5_retire", 4'd7, 16'h0000, 1'b0);
        chk("t5_cnt", 32'(instr_cnt), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step; co("t5_idle", 4'd0, 16'h0000, 1'b0);
        end

        // JMP: FETCH, DECODE, JMPS, RETIRE
        run = 1'b1; ire = 8'hC8;
        step; step;
        step; co("jmp_jmps", 4'd6, 16'h0C00, 1'b1);
        step; co("jmp_retire", 4'd7, 16'h0000, 1'b0);
        chk("jmp_cnt", 32'(instr_cnt), 32'd2);
        run = 1'b0;
        step;

        // 6a: async reset while in MRD with mem_req high
        run = 1'b1; ire = 8'hC4; mem_ack = 1'b1;
        step; step;
        mem_ack = 1'b0;
        step; co("t6_mrd", 4'd5, 16'h1600, 1'b1);
        run = 1'b0;
        #2 reset = 1'b1;
        #1 co("t6_async_rst", 4'd0, 16'h0000, 1'b0);
        chk("t6_rst_cnt", 32'(instr_cnt), 32'd0);
        #2 reset = 1'b0;
        step; co("t6_restart_idle", 4'd0, 16'h0000, 1'b0);

        // 6b: 16 NOPs wrap the 4-bit counter
        run = 1'b1; ire = 8'hC0; mem_ack = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            logic [3:0] e;
            e = i[3:0];
            step; chk("t6_nop_fetch", 32'(state_dbg), 32'd1);
            step; chk("t6_nop_decode", 32'(state_dbg), 32'd2);
            step; chk("t6_nop_retire", 32'(state_dbg), 32'd7);
            chk("t6_nop_cnt", 32'(instr_cnt), 32'(e));
        end
        run = 1'b0;
        step; co("t6_end_idle", 4'd0, 16'h0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
